// File: rtl/lift_ctrl_nfloor_if.sv
// lift_ctrl_nfloor_if: request/status bundle between the button logic,
// the lift controller and the motor/door drivers.
// master = requester / observer side, slave = controller side.
interface lift_ctrl_nfloor_if #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
);
  logic [N_FLOORS-1:0] req;
  logic [1:0]          lift_state;
  logic [FLOOR_W-1:0]  current_floor;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;

  modport master (output req, input lift_state, current_floor, door_open, pending);
  modport slave  (input req, output lift_state, current_floor, door_open, pending);
endinterface

// File: rtl/lift_ctrl_nfloor.sv
// lift_ctrl_nfloor: single-car SCAN lift controller for N_FLOORS floors.
// Requests latch into a pending register; the car travels TRAVEL_CYCLES per
// floor and holds the door open DOOR_CYCLES per served floor.
// Optional macro LIFT_HOME_RETURN_EN: after IDLE_TIMEOUT idle cycles with
// nothing pending the car returns to floor 0 (no door phase on arrival).
// One shared timer serves travel, door and idle counting, since only one of
// them is ever live in a given state.
module lift_ctrl_nfloor #(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int IDLE_TIMEOUT  = 5
) (
  input logic               clk,
  input logic               rst_n,
  lift_ctrl_nfloor_if.slave bus
);
  localparam int TD_MAX  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_MAX = (TD_MAX > IDLE_TIMEOUT) ? TD_MAX : IDLE_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef logic [TMR_W-1:0]   tmr_t;
  typedef logic [FLOOR_W-1:0] floor_t;

  localparam tmr_t   TRAVEL_LD = tmr_t'(TRAVEL_CYCLES);
  localparam tmr_t   DOOR_LD   = tmr_t'(DOOR_CYCLES);
  localparam floor_t TOP       = floor_t'(N_FLOORS - 1);
`ifdef LIFT_HOME_RETURN_EN
  localparam tmr_t   IDLE_LAST = tmr_t'(IDLE_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b10,
    S_DOWN = 2'b01,
    S_DOOR = 2'b11
  } state_t;

  state_t              state_q, state_d;
  floor_t              floor_q, floor_d, arr_floor;
  logic [N_FLOORS-1:0] pend_q, pend_d, pend_in, served;
  tmr_t                tmr_q, tmr_d;
  logic                up_q, up_d;     // last_dir, 1 = up
  logic                above, below, scan_up, arr_above, arr_below;
`ifdef LIFT_HOME_RETURN_EN
  logic                home_q, home_d; // car is on an unrequested trip to floor 0
`endif

  function automatic logic any_above(input logic [N_FLOORS-1:0] v, input floor_t f);
    any_above = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (v[i] && (i > int'(f))) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] v, input floor_t f);
    any_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (v[i] && (i < int'(f))) any_below = 1'b1;
  endfunction

  // Requests seen this cycle count immediately, so a same-cycle req is servable.
  assign pend_in   = pend_q | bus.req;
  assign arr_floor = (state_q == S_UP) ? floor_q + floor_t'(1) : floor_q - floor_t'(1);
  assign above     = any_above(pend_in, floor_q);
  assign below     = any_below(pend_in, floor_q);
  assign arr_above = any_above(pend_in, arr_floor);
  assign arr_below = any_below(pend_in, arr_floor);
  // Keep last direction if it still has work, otherwise turn around.
  assign scan_up   = up_q ? above : !below;

  // Next-state, timer and served-floor selection.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    tmr_d   = tmr_q;
    up_d    = up_q;
    served  = '0;
`ifdef LIFT_HOME_RETURN_EN
    home_d  = home_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (pend_in[floor_q]) begin
          served[floor_q] = 1'b1;
          state_d         = S_DOOR;
          tmr_d           = DOOR_LD;
        end else if (above || below) begin
          state_d = scan_up ? S_UP : S_DOWN;
          up_d    = scan_up;
          tmr_d   = TRAVEL_LD;
        end
`ifdef LIFT_HOME_RETURN_EN
        else if (floor_q != '0) begin
          // Nothing pending here: the timer counts idle cycles.
          if (tmr_q == IDLE_LAST) begin
            state_d = S_DOWN;
            up_d    = 1'b0;
            tmr_d   = TRAVEL_LD;
            home_d  = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
`endif
      end
      S_UP, S_DOWN: begin
        if ((state_q == S_UP && floor_q == TOP) || (state_q == S_DOWN && floor_q == '0)) begin
          // Unreachable by construction; never drive past the shaft ends.
          state_d = S_IDLE;
          tmr_d   = '0;
`ifdef LIFT_HOME_RETURN_EN
          home_d  = 1'b0;
`endif
        end else if (tmr_q > tmr_t'(1)) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          floor_d = arr_floor;
`ifdef LIFT_HOME_RETURN_EN
          // Any real request hands control back to normal SCAN.
          home_d  = home_q && (pend_in == '0) && (arr_floor != '0);
`endif
          if (pend_in[arr_floor]) begin
            served[arr_floor] = 1'b1;
            state_d           = S_DOOR;
            tmr_d             = DOOR_LD;
          end else if ((state_q == S_UP) ? arr_above : arr_below) begin
            tmr_d = TRAVEL_LD;
          end
`ifdef LIFT_HOME_RETURN_EN
          else if (home_d) begin
            tmr_d = TRAVEL_LD;
          end
`endif
          else begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end
        end
      end
      S_DOOR: begin
        if (pend_in[floor_q]) begin
          // Button pressed for this floor while open: hold the door longer.
          served[floor_q] = 1'b1;
          tmr_d           = DOOR_LD;
        end else if (tmr_q > tmr_t'(1)) begin
          tmr_d = tmr_q - 1'b1;
        end else if (above || below) begin
          state_d = scan_up ? S_UP : S_DOWN;
          up_d    = scan_up;
          tmr_d   = TRAVEL_LD;
        end else begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Clear wins over set for the floor being served.
    pend_d = pend_in & ~served;
  end

  // State, position, pending and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      pend_q  <= '0;
      tmr_q   <= '0;
      up_q    <= 1'b1;
`ifdef LIFT_HOME_RETURN_EN
      home_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
      up_q    <= up_d;
`ifdef LIFT_HOME_RETURN_EN
      home_q  <= home_d;
`endif
    end
  end

  assign bus.lift_state    = state_q;
  assign bus.current_floor = floor_q;
  assign bus.door_open     = (state_q == S_DOOR);
  assign bus.pending       = pend_q;
endmodule

// File: tb/tb_lift_ctrl_nfloor.sv
// tb_lift_ctrl_nfloor: directed scenarios plus random requests, every cycle
// compared against a behavioural SCAN lift model.
module tb_lift_ctrl_nfloor;
  localparam int N       = 8;
  localparam int FW      = 3;
  localparam int TRAV    = 4;
  localparam int DOOR    = 3;
  localparam int IDLE_TO = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lift_ctrl_nfloor_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus ();

  lift_ctrl_nfloor #(
    .N_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAV),
    .DOOR_CYCLES(DOOR), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 going up, 2 going down, 3 door open
  int m_mode, m_floor, m_left, m_idle;
  bit m_up, m_home;
  bit m_pend[N];

  function automatic bit m_any(input bit up, input int f);
    for (int i = 0; i < N; i++)
      if (m_pend[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_none();
    for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] m_pvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [1:0] m_code();
    case (m_mode)
      1: return 2'b10;
      2: return 2'b01;
      3: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_floor = 0; m_left = 0; m_idle = 0; m_up = 1'b1; m_home = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endtask

  task automatic m_go(input bit up);
    m_mode = up ? 1 : 2;
    m_up   = up;
    m_left = TRAV;
  endtask

  task automatic m_step(input logic [N-1:0] r);
    bit a, b, up;
    for (int i = 0; i < N; i++) if (r[i]) m_pend[i] = 1'b1;
    case (m_mode)
      0: begin
        a = m_any(1, m_floor);
        b = m_any(0, m_floor);
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_mode = 3; m_left = DOOR; m_idle = 0;
        end else if (a || b) begin
          m_idle = 0;
          m_go(m_up ? a : !b);
        end
`ifdef LIFT_HOME_RETURN_EN
        else if (m_floor != 0) begin
          m_idle++;
          if (m_idle == IDLE_TO) begin m_idle = 0; m_home = 1'b1; m_go(1'b0); end
        end
`endif
        else m_idle = 0;
      end
      1, 2: begin
        up = (m_mode == 1);
        if ((up && m_floor == N - 1) || (!up && m_floor == 0)) begin
          m_mode = 0; m_home = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_floor += up ? 1 : -1;
            if (!m_none() || m_floor == 0) m_home = 1'b0;
            if (m_pend[m_floor]) begin
              m_pend[m_floor] = 1'b0; m_mode = 3; m_left = DOOR;
            end else if (m_any(up, m_floor) || m_home) m_left = TRAV;
            else m_mode = 0;
          end
        end
      end
      default: begin
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_left = DOOR;
        end else begin
          m_left--;
          if (m_left == 0) begin
            a = m_any(1, m_floor);
            b = m_any(0, m_floor);
            if (a || b) m_go(m_up ? a : !b);
            else m_mode = 0;
          end
        end
      end
    endcase
  endtask

  // ---------------- drivers ----------------
  bit prev_door = 1'b0;
  int dq[$];       // floors at which the door opened, in order
  int door_cnt = 0;

  task automatic cycle(input string tag, input logic [N-1:0] r);
    bus.req = r;
    @(posedge clk);
    m_step(r);
    #1;
    chk({tag, "_state"}, bus.lift_state, m_code());
    chk({tag, "_floor"}, bus.current_floor, m_floor);
    chk({tag, "_door"}, bus.door_open, m_mode == 3);
    chk({tag, "_pend"}, bus.pending, m_pvec());
    if (bus.door_open) door_cnt++;
    if (bus.door_open && !prev_door) dq.push_back(int'(bus.current_floor));
    prev_door = bus.door_open;
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    bus.req = '0;
    #1;
    chk({tag, "_rst_state"}, bus.lift_state, 2'b00);
    chk({tag, "_rst_floor"}, bus.current_floor, 0);
    chk({tag, "_rst_door"}, bus.door_open, 1'b0);
    chk({tag, "_rst_pend"}, bus.pending, 0);
    m_reset();
    prev_door = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int guard;
    bus.req = '0;
    m_reset();
    #1;
    chk("por_state", bus.lift_state, 2'b00);
    chk("por_floor", bus.current_floor, 0);
    chk("por_door", bus.door_open, 1'b0);
    chk("por_pend", bus.pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single request for floor 5 from ground
    r = '0; r[5] = 1'b1;
    cycle("s1", r);
    chk("s1_up_next", bus.lift_state, 2'b10);
    repeat (40) cycle("s1", '0);
    chk("s1_end_floor", bus.current_floor, 5);
    chk("s1_end_idle", bus.lift_state, 2'b00);

    // 2: current-floor request, re-pressed during the door phase
    do_reset("s2");
    dq.delete(); door_cnt = 0;
    cycle("s2", 8'h01);
    chk("s2_door_next", bus.door_open, 1'b1);
    cycle("s2", 8'h00);
    cycle("s2", 8'h01);
    repeat (6) cycle("s2", '0);
    chk("s2_door_cycles", door_cnt, 5);
    chk("s2_door_phases", dq.size(), 1);

    // 3: SCAN ordering 3, 6, 1
    r = '0; r[6] = 1'b1;
    cycle("s3", r);
    guard = 0;
    while (!(m_mode == 1 && m_floor == 1) && guard < 50) begin cycle("s3", '0); guard++; end
    chk("s3_reach_f1", guard < 50, 1'b1);
    dq.delete();
    r = '0; r[3] = 1'b1; r[1] = 1'b1;
    cycle("s3", r);
    repeat (80) cycle("s3", '0);
    chk("s3_n_stops", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("s3_stop0", dq[0], 3);
      chk("s3_stop1", dq[1], 6);
      chk("s3_stop2", dq[2], 1);
    end

    // 4: reset mid-move at floor 2 heading up
    do_reset("s4a");
    r = '0; r[7] = 1'b1;
    cycle("s4", r);
    guard = 0;
    while (!(m_mode == 1 && m_floor == 2) && guard < 50) begin cycle("s4", '0); guard++; end
    chk("s4_reach_f2", guard < 50, 1'b1);
    do_reset("s4b");
    repeat (10) cycle("s4", '0);
    chk("s4_still_idle", bus.lift_state, 2'b00);

    // 5: request arriving in the exact arrival cycle at floor 4
    r = '0; r[6] = 1'b1;
    cycle("s5", r);
    guard = 0;
    while (!(m_mode == 1 && m_floor == 3 && m_left == 1) && guard < 50) begin
      cycle("s5", '0); guard++;
    end
    chk("s5_reach_arr", guard < 50, 1'b1);
    dq.delete();
    r = '0; r[4] = 1'b1;
    cycle("s5", r);
    chk("s5_door_at4", bus.door_open, 1'b1);
    repeat (30) cycle("s5", '0);
    chk("s5_n_stops", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("s5_stop0", dq[0], 4);
      chk("s5_stop1", dq[1], 6);
    end
    chk("s5_pend_clear", bus.pending, 0);

    // 6: idle at floor 4 (home return only with the macro)
    do_reset("s6");
    r = '0; r[4] = 1'b1;
    cycle("s6", r);
    repeat (25) cycle("s6", '0);
    dq.delete();
    repeat (40) cycle("s6", '0);
    chk("s6_no_door", dq.size(), 0);
`ifdef LIFT_HOME_RETURN_EN
    chk("s6_floor", bus.current_floor, 0);
`else
    chk("s6_floor", bus.current_floor, 4);
`endif

    // 7: random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd");
        continue;
      end
      if ($urandom_range(0, 4) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) r[m_floor] = 1'b1;
      if ($urandom_range(0, 39) == 0) r = N'($urandom);
      cycle("rnd", r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lift_ctrl_nfloor.md
Name: lift_ctrl_nfloor

Overview:
Parametrised single-car lift controller, the successor to the 4-floor request-follower. Per-floor request bits are latched into a pending register and served in SCAN (elevator) order. Travel takes a fixed number of cycles per floor, and each served floor gets a timed door-open phase. The block sits between the request/button logic and the car motor/door drivers.

Parameters:
N_FLOORS, 8, number of floors (2..64); floor 0 is ground.
FLOOR_W, $clog2(N_FLOORS), width of floor index.
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
DOOR_CYCLES, 3, clock cycles door stays open (>=1).
IDLE_TIMEOUT, 5, idle cycles before home return (used only with the optional feature).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_FLOORS  per-floor request; any cycle high sets the pending bit.
lift_state  output  2  00 idle, 10 up, 01 down, 11 door open.
current_floor  output  FLOOR_W  last floor reached.
door_open  output  1  high exactly while lift_state==11.
pending  output  N_FLOORS  latched, not-yet-served requests.

Behaviour:
- Reset (async, rst_n=0): lift_state=00, current_floor=0, door_open=0, pending=0, travel/door/idle timers=0, last_dir=up. This takes effect immediately, including mid-move or mid-door; the car restarts from floor 0.
- pending_next = (pending | req) & ~served_mask. served_mask has a single bit, for the floor being served this cycle. Clear wins over set for the same bit in the same cycle, so that request counts as served.
- "Above" = any pending bit > current_floor. "Below" = any pending bit < current_floor.
- IDLE:
  - pending[current_floor] set → DOOR_OPEN next cycle; bit cleared.
  - else above/below present → choose last_dir if requests exist that way, else the other direction → MOVE_UP/MOVE_DOWN; travel timer loads TRAVEL_CYCLES.
  - else stay IDLE.
- MOVE_UP / MOVE_DOWN:
  - Timer decrements each cycle. On the cycle it reaches 1, current_floor is ±1 (next cycle value) = the arrival edge.
  - Arrival floor pending → DOOR_OPEN, bit cleared.
  - Else requests remain in the travel direction → stay moving, timer reloaded.
  - Else → IDLE evaluation next cycle.
  - current_floor never leaves 0..N_FLOORS-1. Moving up at the top floor or down at floor 0 is impossible by construction; if reached, the state forces to IDLE.
  - A request for the departure floor during a move stays pending and is served later.
- DOOR_OPEN:
  - door_open=1 for DOOR_CYCLES cycles.
  - A req for current_floor while open is cleared and reloads the door timer.
  - On expiry, SCAN decision: continue last_dir if requests exist that way; else reverse if requests exist the other way; else IDLE.
- last_dir updates whenever a MOVE state is entered.
- Minimum latency: req for current floor while IDLE → door_open on the next rising edge.
- req bits may be held high. A held bit for the current floor in IDLE gives repeated door cycles; this is intended behaviour.

Optional Feature:
Macro LIFT_HOME_RETURN_EN.
- Defined: the idle counter increments in IDLE with pending==0 and current_floor!=0; it resets on any other condition. On reaching IDLE_TIMEOUT → MOVE_DOWN toward floor 0. At floor 0 the car goes to IDLE with no door phase. Any new request during the return is handled by normal SCAN rules.
- Undefined: the car stays idle at its last floor indefinitely; IDLE_TIMEOUT is unused.

Test Plan:
- Defaults. Reset, then pulse req[5] one cycle → lift_state=10 next cycle; current_floor steps 1..5 every 4 cycles (floor 5 after 20 cycles); door_open=1 for 3 cycles; lift_state=00; pending=0.
- Idle at floor 0, pulse req[0] → door_open=1 next cycle for 3 cycles; current_floor stays 0; never 10/01. Pulse req[0] again during the door phase → door stays open 3 cycles after that pulse.
- At floor 0, req[6]. While between floors 1 and 2, pulse req[3] and req[1] → stops at 3, then 6, then lift_state=01 and stops at 1; SCAN order 3,6,1.
- Mid-move at floor 2 heading up, drop rst_n → lift_state=00, current_floor=0, pending=0 immediately, without waiting for clk. Release, no requests → stays idle.
- Pulse req[4] in the exact cycle the car arrives at floor 4 → single door phase; pending[4]=0 afterwards; no second door phase.
- LIFT_HOME_RETURN_EN defined, IDLE_TIMEOUT=5. Car idle at floor 4 with pending=0 → after 5 idle cycles lift_state=01; reaches floor 0 after 16 cycles; door_open stays 0. Undefined → car remains at floor 4.
